// File: rtl/frame_pick.sv
// frame_pick: hunts an input word stream for a sync header (SYNC0 repeated at
// least SYNC0_REPEAT times, then SYNC1), captures the control word that
// follows, and then extracts one frame of pixels. The frame length is either
// fixed (NUM_PIXELS) or taken from the low CNT_WIDTH bits of the control word.
// A cycle with DIN_VALID=0 changes no state. Every output is registered, so
// the response to a word accepted in cycle N appears in cycle N+1.
//
// Ports:
//   CLK          clock, all logic on the rising edge
//   RST          synchronous reset, active high
//   EN           allows a new sync hunt to start; ignored once a header is running
//   DIN_VALID    qualifies DIN
//   DIN          input word
//   PIXEL_VALID  pixel strobe
//   PIXEL_DATA   pixel word, 0 when PIXEL_VALID=0
//   PIXEL_FIRST  with PIXEL_VALID: pixel index 0
//   PIXEL_LAST   with PIXEL_VALID: final pixel of the frame
//   PIXEL_IDX    index of the current pixel, 0 when not valid
//   CNTL_VALID   one-cycle pulse when a control word is captured
//   CNTL_DATA    last captured control word, held until the next capture
//   FRAME_DONE   one-cycle pulse, coincident with PIXEL_LAST
//   SYNC_ERR     one-cycle pulse on a header error or an illegal frame length

module frame_pick #(
    parameter int                     PIXEL_WIDTH  = 16,
    parameter logic [PIXEL_WIDTH-1:0] SYNC0        = 16'hFFFF,
    parameter logic [PIXEL_WIDTH-1:0] SYNC1        = 16'hAAAA,
    parameter int                     SYNC0_REPEAT = 2,
    parameter int                     CNT_MODE     = 0,
    parameter int                     NUM_PIXELS   = 16,
    parameter int                     MAX_PIXELS   = 1024,
    localparam int                    CNT_WIDTH    = $clog2(MAX_PIXELS + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   DIN_VALID,
    input  logic [PIXEL_WIDTH-1:0] DIN,
    output logic                   PIXEL_VALID,
    output logic [PIXEL_WIDTH-1:0] PIXEL_DATA,
    output logic                   PIXEL_FIRST,
    output logic                   PIXEL_LAST,
    output logic [CNT_WIDTH-1:0]   PIXEL_IDX,
    output logic                   CNTL_VALID,
    output logic [PIXEL_WIDTH-1:0] CNTL_DATA,
    output logic                   FRAME_DONE,
    output logic                   SYNC_ERR
);

    // Width of the SYNC0 run counter; it saturates at SYNC0_REPEAT.
    localparam int SC_WIDTH = $clog2(SYNC0_REPEAT + 1);

    localparam logic [SC_WIDTH-1:0]  SYNC_FULL = SC_WIDTH'(SYNC0_REPEAT);
    localparam logic [CNT_WIDTH-1:0] FIXED_LEN = CNT_WIDTH'(NUM_PIXELS);
    localparam logic [CNT_WIDTH-1:0] MAX_LEN   = CNT_WIDTH'(MAX_PIXELS);

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        CNTL,
        PIXEL
    } state_t;

    state_t               state;
    logic [SC_WIDTH-1:0]  sync_cnt;
    logic [CNT_WIDTH-1:0] idx;
    logic [CNT_WIDTH-1:0] len;

    logic [CNT_WIDTH-1:0] cand_len;
    logic                 len_bad;
    logic                 is_last;

    // NOTE: every signal written in this block gets a value on every path,
    // starting with a default, so no latch can be inferred.
    always_comb begin
        cand_len = FIXED_LEN;
        if (CNT_MODE == 1) begin
            cand_len = DIN[CNT_WIDTH-1:0];
        end
        len_bad = (cand_len == '0) || (cand_len > MAX_LEN);
        // len is at least 1 while in PIXEL, so len-1 never underflows there.
        is_last = (idx == len - CNT_WIDTH'(1));
    end

    // NOTE: state and outputs update with non-blocking assignments, so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= HUNT;
            sync_cnt    <= '0;
            idx         <= '0;
            len         <= '0;
            PIXEL_VALID <= 1'b0;
            PIXEL_DATA  <= '0;
            PIXEL_FIRST <= 1'b0;
            PIXEL_LAST  <= 1'b0;
            PIXEL_IDX   <= '0;
            CNTL_VALID  <= 1'b0;
            CNTL_DATA   <= '0;
            FRAME_DONE  <= 1'b0;
            SYNC_ERR    <= 1'b0;
        end else begin
            // Pulses and pixel fields drop unless this cycle's word drives them.
            PIXEL_VALID <= 1'b0;
            PIXEL_DATA  <= '0;
            PIXEL_FIRST <= 1'b0;
            PIXEL_LAST  <= 1'b0;
            PIXEL_IDX   <= '0;
            CNTL_VALID  <= 1'b0;
            FRAME_DONE  <= 1'b0;
            SYNC_ERR    <= 1'b0;

            if (DIN_VALID) begin
                case (state)
                    HUNT: begin
                        if (EN && DIN == SYNC0) begin
                            sync_cnt <= SC_WIDTH'(1);
                            state    <= SYNC;
                        end
                    end

                    SYNC: begin
                        // SYNC0 is tested first so that it wins when SYNC0 == SYNC1.
                        if (DIN == SYNC0) begin
                            if (sync_cnt != SYNC_FULL) begin
                                sync_cnt <= sync_cnt + SC_WIDTH'(1);
                            end
                        end else if (DIN == SYNC1 && sync_cnt == SYNC_FULL) begin
                            state <= CNTL;
                        end else begin
                            // A short run is only noise; a full run followed by
                            // garbage is a broken header.
                            SYNC_ERR <= (sync_cnt == SYNC_FULL);
                            state    <= HUNT;
                        end
                    end

                    CNTL: begin
                        CNTL_DATA  <= DIN;
                        CNTL_VALID <= 1'b1;
                        len        <= cand_len;
                        idx        <= '0;
                        if (len_bad) begin
                            SYNC_ERR <= 1'b1;
                            state    <= HUNT;
                        end else begin
                            state <= PIXEL;
                        end
                    end

                    PIXEL: begin
                        // Payload words are never compared against SYNC0/SYNC1.
                        PIXEL_VALID <= 1'b1;
                        PIXEL_DATA  <= DIN;
                        PIXEL_IDX   <= idx;
                        PIXEL_FIRST <= (idx == '0);
                        PIXEL_LAST  <= is_last;
                        FRAME_DONE  <= is_last;
                        if (is_last) begin
                            idx   <= '0;
                            state <= HUNT;
                        end else begin
                            idx <= idx + CNT_WIDTH'(1);
                        end
                    end

                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: doc/frame_pick.md
Name: frame_pick

Overview:
- Parametrised successor to the fixed 16-pixel sync/pixel picker.
- Hunts an input word stream for a configurable sync header: SYNC0 repeated SYNC0_REPEAT times, then SYNC1.
- Captures the control word that follows, then extracts a frame of pixels. Frame length is either fixed or taken from the control word.
- Supports input stalls (DIN_VALID), registered outputs with first/last/index tags, and error reporting. Sits between the receive deserializer and the pixel pipeline.

Parameters:
- PIXEL_WIDTH, 16, width of every input word and output pixel.
- SYNC0, 16'hFFFF, repeated sync word (PIXEL_WIDTH bits).
- SYNC1, 16'hAAAA, terminating sync word (PIXEL_WIDTH bits).
- SYNC0_REPEAT, 2, minimum consecutive SYNC0 words required (>=1).
- CNT_MODE, 0, 0 = frame length is NUM_PIXELS; 1 = frame length is CNTL word bits [CNT_WIDTH-1:0].
- NUM_PIXELS, 16, fixed frame length in mode 0 (1..MAX_PIXELS).
- MAX_PIXELS, 1024, largest legal frame length.
- CNT_WIDTH, $clog2(MAX_PIXELS+1), derived (localparam); width of the length and index fields.

Ports:
- CLK, input, 1, clock; all logic on posedge.
- RST, input, 1, synchronous reset, active-high.
- EN, input, 1, permits the start of a new sync hunt. Ignored once a header is in progress.
- DIN_VALID, input, 1, qualifies DIN; a word is "accepted" when DIN_VALID=1.
- DIN, input, PIXEL_WIDTH, input word.
- PIXEL_VALID, output, 1, registered pixel strobe.
- PIXEL_DATA, output, PIXEL_WIDTH, pixel word; 0 when PIXEL_VALID=0.
- PIXEL_FIRST, output, 1, with PIXEL_VALID: pixel index 0.
- PIXEL_LAST, output, 1, with PIXEL_VALID: final pixel of the frame.
- PIXEL_IDX, output, CNT_WIDTH, index of the current pixel; 0 when not valid.
- CNTL_VALID, output, 1, one-cycle pulse when the control word is captured.
- CNTL_DATA, output, PIXEL_WIDTH, last captured control word; held until the next capture.
- FRAME_DONE, output, 1, one-cycle pulse coincident with PIXEL_LAST.
- SYNC_ERR, output, 1, one-cycle pulse on a header or length error.

Behaviour:
- Reset:
  - Synchronous on RST=1 at posedge; overrides all inputs.
  - All outputs = 0, including CNTL_DATA. State = HUNT; sync_cnt = 0; idx = 0; len = 0.
  - RST mid-frame aborts the frame; no FRAME_DONE is generated.
- Latency and stalls:
  - All outputs are registered. The response to a word accepted in cycle N appears in cycle N+1.
  - Cycles with DIN_VALID=0 change no state and produce no pulses. PIXEL_VALID=0 in the following cycle.
- State HUNT:
  - If EN=1 and DIN_VALID=1 and DIN==SYNC0: sync_cnt = 1, go to SYNC.
  - Otherwise stay.
- State SYNC (accepted words only):
  - DIN==SYNC0: sync_cnt = min(sync_cnt+1, SYNC0_REPEAT). Runs longer than SYNC0_REPEAT are legal.
  - DIN==SYNC1 and sync_cnt==SYNC0_REPEAT: go to CNTL.
  - Any other word with sync_cnt==SYNC0_REPEAT: SYNC_ERR pulse, go to HUNT.
  - Any other word with sync_cnt<SYNC0_REPEAT: go to HUNT silently.
  - When SYNC0==SYNC1, the SYNC0 comparison takes priority.
- State CNTL:
  - The next accepted word is latched into CNTL_DATA and CNTL_VALID pulses.
  - len = NUM_PIXELS (mode 0) or DIN[CNT_WIDTH-1:0] (mode 1).
  - If len==0 or len>MAX_PIXELS: SYNC_ERR pulse (same cycle as CNTL_VALID), go to HUNT.
  - Otherwise idx = 0, go to PIXEL.
- State PIXEL:
  - Each accepted word is output as PIXEL_DATA with PIXEL_IDX=idx.
  - PIXEL_FIRST = (idx==0). PIXEL_LAST = (idx==len-1).
  - idx increments by 1 per accepted word.
  - On the last pixel: FRAME_DONE pulse, go to HUNT.
  - Words equal to SYNC0/SYNC1 are treated as payload.
  - len==1: FIRST and LAST assert together.
- EN gating:
  - EN=0 blocks only the HUNT->SYNC transition.
  - Deasserting EN mid-header or mid-frame does not abort.
- Back-to-back frames:
  - A SYNC0 word accepted in the cycle after the last pixel starts the next hunt; there is no dead cycle.
- No counter wraps: idx never exceeds MAX_PIXELS-1, and sync_cnt saturates.

Test Plan:
- Default params: FFFF, FFFF, AAAA, 1234, then pixels 0..15 all valid -> CNTL_VALID with CNTL_DATA=16'h1234; 16 PIXEL_VALID cycles with data 0..15. PIXEL_FIRST on idx 0; PIXEL_LAST and FRAME_DONE on idx 15; then back in HUNT.
- Same frame with DIN_VALID=0 inserted every other cycle, and EN dropped after the header -> identical output sequence, with PIXEL_VALID gaps matching the stalls.
- FFFF, FFFF, FFFF, AAAA (long run) accepted; FFFF, AAAA (short run) -> silent return to HUNT; FFFF, FFFF, 5555 -> SYNC_ERR pulse.
- CNT_MODE=1: control word 16'h0003 -> exactly 3 pixels, with idx 0,1,2. Control word 16'h0000 -> SYNC_ERR, no pixels. Control word 16'h07FF (>1024) -> SYNC_ERR.
- Payload containing FFFF, FFFF, AAAA mid-frame -> passed as pixels; no resync. Frame 2 header immediately after LAST -> second frame extracted without gap.
- RST asserted at pixel idx 7 -> all outputs 0 the next cycle; no FRAME_DONE; the next full header yields a clean frame.
